// File: rtl/alu_mdu_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and
// alu_mdu_unit. The master drives the operation, the slave returns the result.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, op, operand_a, operand_b,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mdu_unit.sv
// Integer ALU with an optional iterative radix-2 multiply/divide engine.
// Base ops finish one edge after accept; M ops take XLEN+1 edges.
// Macro ALU_MDU_EN builds the M-extension engine; without it op[4]=1 returns 0
// in one edge and the unit is always ready.
module alu_mdu_unit #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst,
  alu_mdu_if.slave  bus
);
  logic [XLEN-1:0] a, b, alu_res, res_q, res_d;
  logic [SHW-1:0]  shamt;
  logic            ov_q, ov_d;

  assign a     = bus.operand_a;
  assign b     = bus.operand_b;
  assign shamt = b[SHW-1:0];

  // single-cycle base ALU; unused base codes yield 0
  always_comb begin
    alu_res = '0;
    case (bus.op)
      5'b00000: alu_res = a + b;
      5'b00001: alu_res = a - b;
      5'b00010: alu_res = a & b;
      5'b00011: alu_res = a | b;
      5'b00100: alu_res = a ^ b;
      5'b00101: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'b00110: alu_res = {{(XLEN-1){1'b0}}, a < b};
      5'b00111: alu_res = a << shamt;
      5'b01000: alu_res = a >> shamt;
      5'b01001: alu_res = $signed(a) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MDU_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              idle, a_sgn, b_sgn, sa, sb, div_fast, use_div;
  logic [XLEN-1:0]   mag_a, mag_b, fast_val, st_hi, st_lo, st_m;
  logic [XLEN-1:0]   step_hi, step_lo, fix_out;
  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0] prod;

  assign idle  = (state_q == IDLE);
  assign a_sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
  assign b_sgn = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
  assign sa    = a_sgn & a[XLEN-1];
  assign sb    = b_sgn & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // Divide-by-zero and signed overflow never enter the iterative loop.
  assign div_fast = (b == '0) || (~bus.op[0] && a == MINV && b == '1);
  assign fast_val = (b == '0) ? (bus.op[1] ? a : '1) : (bus.op[1] ? '0 : a);

  // The first iteration runs on the accept edge straight from the operand
  // magnitudes, so XLEN iterations plus FIX fit in XLEN+1 edges.
  assign st_hi   = idle ? '0 : hi_q;
  assign st_lo   = idle ? (bus.op[2] ? mag_a : mag_b) : lo_q;
  assign st_m    = idle ? (bus.op[2] ? mag_b : mag_a) : m_q;
  assign use_div = idle ? bus.op[2] : (state_q == DIV);

  // mul: {hi,lo} is accumulator/multiplier, shifted right each step
  // div: hi is the partial remainder, lo shifts dividend out and quotient in
  assign mul_sum  = {1'b0, st_hi} + (st_lo[0] ? {1'b0, st_m} : '0);
  assign div_rs   = {st_hi, st_lo[XLEN-1]};
  assign div_diff = div_rs - {1'b0, st_m};
  assign step_hi  = use_div ? (div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0])
                            : mul_sum[XLEN:1];
  assign step_lo  = use_div ? {st_lo[XLEN-2:0], ~div_diff[XLEN]}
                            : {mul_sum[0], st_lo[XLEN-1:1]};

  assign prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  // sign correction and half / quotient-remainder selection
  always_comb begin
    if (mop_q[2]) fix_out = mop_q[1] ? (rneg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
    else          fix_out = (mop_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // FSM next state and datapath updates
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (!bus.op[4] || bus.op[3]) begin
          res_d = bus.op[4] ? '0 : alu_res;
          ov_d  = 1'b1;
        end else if (bus.op[2] && div_fast) begin
          res_d = fast_val;
          ov_d  = 1'b1;
        end else begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          m_d     = st_m;
          cnt_d   = '0;
          mop_d   = bus.op[2:0];
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          state_d = bus.op[2] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-2)) state_d = FIX;
      end
      FIX: begin
        res_d   = fix_out;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      mop_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready = idle;
  assign bus.busy     = ~idle;
`else
  // every op completes in one edge; M codes return 0
  always_comb begin
    res_d = res_q;
    ov_d  = 1'b0;
    if (bus.in_valid) begin
      res_d = bus.op[4] ? '0 : alu_res;
      ov_d  = 1'b1;
    end
  end

  // result register
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      ov_q  <= ov_d;
    end
  end

  assign bus.in_ready = 1'b1;
  assign bus.busy     = 1'b0;
`endif

  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_alu_mdu_unit.sv
// Scoreboard bench for alu_mdu_unit: the issuer pushes expected result and
// completion cycle; a negedge monitor checks handshake state every cycle and
// pops/compares on each out_valid.
module tb_alu_mdu_unit;
  localparam int XLEN = 32;
`ifdef ALU_MDU_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_if #(.XLEN(XLEN)) bus();
  alu_mdu_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [4:0]  op;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model from the ISA definitions, using wide integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int                ia, ib;
    longint            ps;
    longint unsigned   pu;
    logic [31:0]       r;
    bit                ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = (ia < ib) ? 32'd1 : 32'd0;
      5'd6:  r = (a < b) ? 32'd1 : 32'd0;
      5'd7:  r = a << b[4:0];
      5'd8:  r = a >> b[4:0];
      5'd9:  r = ia >>> b[4:0];
`ifdef ALU_MDU_EN
      5'd16: begin pu = longint'(a) * longint'(b); r = pu[31:0]; end
      5'd17: begin ps = longint'(ia) * longint'(ib); r = ps[63:32]; end
      5'd18: begin ps = longint'(ia) * longint'(b); r = ps[63:32]; end
      5'd19: begin pu = longint'(a) * longint'(b); r = pu[63:32]; end
      5'd20: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : ia / ib;
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: r = (b == 0) ? a : ovf ? 32'd0 : ia % ib;
      5'd23: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!MEN || !op[4] || op[3]) return 1;
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  // Present an op, hold in_valid until accepted, then record the expectation.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res);
    int   waited;
    int   exp_acc;
    int   lat;
    exp_t e;
    waited = 0;
    @(negedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    exp_acc = (cyc >= free_cyc) ? cyc : free_cyc;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("FAIL accept timeout: op %h never accepted, in_ready still %b", op, bus.in_ready);
    end else begin
      chk("accept cycle", cyc, exp_acc);
      lat      = ref_lat(op, a, b);
      e.res    = exp_res;
      e.due    = cyc + lat;
      e.op     = op;
      free_cyc = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_m);
    issue(op, a, b, MEN ? exp_m : 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // monitor: handshake state each cycle, result/latency on every out_valid
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, cyc >= free_cyc});
      chk("busy", {31'd0, bus.busy}, {31'd0, cyc < free_cyc});
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL spurious out_valid: result %h with nothing outstanding (cycle %0d)", bus.result, cyc);
        end else begin
          e = q.pop_front();
          chk("result", bus.result, e.res);
          chk("zero", {31'd0, bus.zero}, {31'd0, e.res == 0});
          chk("out_valid cycle", cyc, e.due);
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        e = q.pop_front();
        checks++;
        $display("FAIL missing out_valid: op %h due cycle %0d, now %0d", e.op, e.due, cyc);
      end
    end
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", {31'd0, bus.zero}, 32'd1);
    #1 rst = 1'b0;

    // directed cases
    issue(5'd0, 32'd5, 32'd7, 32'd12);
    issue(5'd1, 32'd7, 32'd7, 32'd0);
    issue(5'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);
    issue(5'd8, 32'h8000_0000, 32'd4, 32'h0800_0000);
    issue(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue(5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue(5'd7, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    issue(5'd11, 32'd3, 32'd4, 32'd0);
    issue_m(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    issue_m(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue_m(5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    issue_m(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue_m(5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue_m(5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue_m(5'd21, 32'd9, 32'd0, 32'hFFFF_FFFF);
    issue_m(5'd23, 32'd9, 32'd0, 32'd9);
    issue_m(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue_m(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(5'd31, 32'd1, 32'd1, 32'd0);

    // ADD presented while a DIV is in flight waits for the DIV's completion cycle
    issue_m(5'd20, 32'd100, 32'd7, 32'd14);
    issue(5'd0, 32'd1, 32'd2, 32'd3);

    // reset 10 cycles into a MULHU aborts it
    issue_m(5'd19, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    q.delete();
    free_cyc = 0;
    @(negedge clk);
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort result", bus.result, 32'd0);
    chk("abort zero", {31'd0, bus.zero}, 32'd1);
    #1 rst = 1'b0;
    issue(5'd0, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123);

    // randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = pick();
      rb  = pick();
      issue(rop, ra, rb, ref_res(rop, ra, rb));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL drain: op %h due cycle %0d never completed", e.op, e.due);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
